// File: rtl/l2_cache_tag_update_pkg.sv
// Shared types and geometry for the L2 tag-update stage.
// Build option: L2_TAG_PERF_COUNTERS_EN adds hit/miss counters.
package l2_cache_tag_update_pkg;

  localparam int L2_NUM_WAYS   = 8;
  localparam int L2_NUM_SETS   = 256;
  localparam int L2_TAG_WIDTH  = 18;
  localparam int L2_LINE_BYTES = 64;

  localparam int L2_WAY_W  = $clog2(L2_NUM_WAYS);
  localparam int L2_SET_W  = $clog2(L2_NUM_SETS);
  localparam int L2_OFS_W  = $clog2(L2_LINE_BYTES);
  localparam int L2_ADDR_W = L2_TAG_WIDTH + L2_SET_W + L2_OFS_W;
  localparam int L2_LINE_W = L2_LINE_BYTES * 8;

  typedef enum logic [1:0] {
    PKT_LOAD     = 2'd0,
    PKT_STORE    = 2'd1,
    PKT_FLUSH    = 2'd2,
    PKT_PREFETCH = 2'd3
  } l2_pkt_type_t;

  typedef logic [L2_ADDR_W-1:0]    l2_addr_t;
  typedef logic [L2_TAG_WIDTH-1:0] l2_tag_t;
  typedef logic [L2_SET_W-1:0]     l2_set_idx_t;
  typedef logic [L2_WAY_W-1:0]     l2_way_idx_t;
  typedef logic [L2_LINE_W-1:0]    cache_line_data_t;

  typedef struct packed {
    logic         valid;
    l2_pkt_type_t packet_type;
    l2_addr_t     address;
  } l2req_packet_t;

  function automatic l2_tag_t addr_tag(
    input l2_addr_t a
  );
    return a[L2_ADDR_W-1 -: L2_TAG_WIDTH];
  endfunction

  function automatic l2_set_idx_t addr_set(
    input l2_addr_t a
  );
    return a[L2_OFS_W +: L2_SET_W];
  endfunction

endpackage

// File: rtl/l2_cache_tag_update_sweep_fsm.sv
// Whole-cache invalidate sweep: walks every set once,
// yielding the update ports to any valid request.
module l2_sweep_fsm
  import l2_cache_tag_update_pkg::*;
#(
  parameter int NUM_SETS = L2_NUM_SETS,
  localparam int SET_W   = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sweep_start,
  input  logic             hold,
  output logic             sweep_wr,
  output logic [SET_W-1:0] sweep_set,
  output logic             sweep_busy,
  output logic             sweep_done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } sweep_state_t;

  localparam logic [SET_W-1:0] LAST = SET_W'(NUM_SETS - 1);

  sweep_state_t     state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        if (!hold) begin
          if (cnt_q == LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sweep_busy = (state_q == S_SWEEP);
    sweep_wr   = sweep_busy && !hold;
    sweep_set  = cnt_q;
    sweep_done = done_q;
  end

endmodule

// File: rtl/l2_cache_tag_update.sv
// L2 hit detection, tag/dirty/LRU update writer and update-stage register.
// Build option: L2_TAG_PERF_COUNTERS_EN adds perf_l2_hits/perf_l2_misses.
module l2_cache_tag_update
  import l2_cache_tag_update_pkg::*;
#(
  parameter int NUM_WAYS  = L2_NUM_WAYS,
  parameter int NUM_SETS  = L2_NUM_SETS,
  parameter int TAG_WIDTH = L2_TAG_WIDTH,
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  l2req_packet_t                      l2t_request,
  input  logic [NUM_WAYS-1:0]                l2t_valid,
  input  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] l2t_tag,
  input  logic [NUM_WAYS-1:0]                l2t_dirty,
  input  logic                               l2t_is_l2_fill,
  input  logic [WAY_W-1:0]                   l2t_fill_way,
  input  cache_line_data_t                   l2t_data_from_memory,
  input  logic                               sweep_start,
  output logic [NUM_WAYS-1:0]                l2r_update_tag_en,
  output logic [SET_W-1:0]                   l2r_update_tag_set,
  output logic                               l2r_update_tag_valid,
  output logic [TAG_WIDTH-1:0]               l2r_update_tag_value,
  output logic [NUM_WAYS-1:0]                l2r_update_dirty_en,
  output logic [SET_W-1:0]                   l2r_update_dirty_set,
  output logic                               l2r_update_dirty_value,
  output logic                               l2r_update_lru_en,
  output logic [WAY_W-1:0]                   l2r_update_lru_hit_way,
  output logic                               sweep_busy,
  output logic                               sweep_done,
`ifdef L2_TAG_PERF_COUNTERS_EN
  output logic [31:0]                        perf_l2_hits,
  output logic [31:0]                        perf_l2_misses,
`endif
  output l2req_packet_t                      l2u_request,
  output logic                               l2u_hit,
  output logic [WAY_W-1:0]                   l2u_hit_way,
  output logic                               l2u_is_l2_fill,
  output cache_line_data_t                   l2u_data_from_memory,
  output logic                               l2u_writeback_needed,
  output logic [TAG_WIDTH-1:0]               l2u_writeback_tag
);

  logic [TAG_WIDTH-1:0] req_tag;
  logic [SET_W-1:0]     req_set;
  logic [NUM_WAYS-1:0]  hit;
  logic [WAY_W-1:0]     hit_way;
  logic                 any_hit;
  logic                 is_store;
  logic                 fill_miss;
  logic                 wb_needed;
  logic                 sweep_wr;
  logic [SET_W-1:0]     sweep_set;

  assign req_tag  = addr_tag(l2t_request.address);
  assign req_set  = addr_set(l2t_request.address);
  assign is_store = (l2t_request.packet_type == PKT_STORE);

  always_comb begin
    hit = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit[w] = l2t_request.valid && l2t_valid[w]
            && (l2t_tag[w] == req_tag);
    end
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit[w]) hit_way = hit_way | WAY_W'(w);
    end
  end

  assign any_hit   = |hit;
  assign fill_miss = l2t_request.valid && l2t_is_l2_fill && !any_hit;
  assign wb_needed = fill_miss && l2t_valid[l2t_fill_way]
                  && l2t_dirty[l2t_fill_way];

  l2_sweep_fsm #(
    .NUM_SETS (NUM_SETS)
  ) u_sweep (
    .clk         (clk),
    .reset       (reset),
    .sweep_start (sweep_start),
    .hold        (l2t_request.valid),
    .sweep_wr    (sweep_wr),
    .sweep_set   (sweep_set),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done)
  );

  // Reset gates every enable so a stray request cannot write metadata.
  always_comb begin
    l2r_update_tag_en      = '0;
    l2r_update_tag_set     = req_set;
    l2r_update_tag_valid   = 1'b0;
    l2r_update_tag_value   = req_tag;
    l2r_update_dirty_en    = '0;
    l2r_update_dirty_set   = req_set;
    l2r_update_dirty_value = 1'b0;
    l2r_update_lru_en      = 1'b0;
    l2r_update_lru_hit_way = hit_way;
    if (reset) begin
      unique case (1'b1)
        any_hit: begin
          l2r_update_lru_en = 1'b1;
          if (is_store) begin
            l2r_update_dirty_en[hit_way] = 1'b1;
            l2r_update_dirty_value       = 1'b1;
          end
        end
        fill_miss: begin
          l2r_update_tag_en[l2t_fill_way]   = 1'b1;
          l2r_update_tag_valid              = 1'b1;
          l2r_update_dirty_en[l2t_fill_way] = 1'b1;
          l2r_update_dirty_value            = is_store;
          l2r_update_lru_en                 = 1'b1;
          l2r_update_lru_hit_way            = l2t_fill_way;
        end
        sweep_wr: begin
          l2r_update_tag_en    = '1;
          l2r_update_tag_set   = sweep_set;
          l2r_update_dirty_en  = '1;
          l2r_update_dirty_set = sweep_set;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l2u_request          <= '0;
      l2u_hit              <= 1'b0;
      l2u_hit_way          <= '0;
      l2u_is_l2_fill       <= 1'b0;
      l2u_data_from_memory <= '0;
      l2u_writeback_needed <= 1'b0;
      l2u_writeback_tag    <= '0;
    end else begin
      l2u_request          <= l2t_request;
      l2u_hit              <= any_hit;
      l2u_hit_way          <= fill_miss ? l2t_fill_way : hit_way;
      l2u_is_l2_fill       <= l2t_is_l2_fill;
      l2u_data_from_memory <= l2t_data_from_memory;
      l2u_writeback_needed <= wb_needed;
      l2u_writeback_tag    <= l2t_tag[l2t_fill_way];
    end
  end

`ifdef L2_TAG_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_l2_hits   <= '0;
      perf_l2_misses <= '0;
    end else begin
      if (any_hit)
        perf_l2_hits <= perf_l2_hits + 32'd1;
      if (l2t_request.valid && !any_hit && !l2t_is_l2_fill)
        perf_l2_misses <= perf_l2_misses + 32'd1;
    end
  end
`endif

  a_onehot_hit: assert property (
    @(posedge clk) disable iff (!reset) $onehot0(hit)
  ) else $error("multiple L2 hit ways");

endmodule

// File: tb/tb_l2_cache_tag_update.sv
// Directed bench for l2_cache_tag_update: hits, fills, writeback, sweep.
module tb_l2_cache_tag_update;
  import l2_cache_tag_update_pkg::*;

  logic                   clk;
  logic                   reset;
  l2req_packet_t          l2t_request;
  logic [7:0]             l2t_valid;
  logic [7:0][17:0]       l2t_tag;
  logic [7:0]             l2t_dirty;
  logic                   l2t_is_l2_fill;
  logic [2:0]             l2t_fill_way;
  cache_line_data_t       l2t_data_from_memory;
  logic                   sweep_start;
  logic [7:0]             tag_en;
  logic [7:0]             tag_set;
  logic                   tag_valid;
  logic [17:0]            tag_value;
  logic [7:0]             dirty_en;
  logic [7:0]             dirty_set;
  logic                   dirty_value;
  logic                   lru_en;
  logic [2:0]             lru_way;
  logic                   sweep_busy;
  logic                   sweep_done;
  l2req_packet_t          l2u_request;
  logic                   l2u_hit;
  logic [2:0]             l2u_hit_way;
  logic                   l2u_is_l2_fill;
  cache_line_data_t       l2u_data;
  logic                   l2u_wb;
  logic [17:0]            l2u_wb_tag;
`ifdef L2_TAG_PERF_COUNTERS_EN
  logic [31:0]            perf_hits;
  logic [31:0]            perf_misses;
`endif

  int errors = 0;
  int checks = 0;

  l2_cache_tag_update dut (
    .clk                    (clk),
    .reset                  (reset),
    .l2t_request            (l2t_request),
    .l2t_valid              (l2t_valid),
    .l2t_tag                (l2t_tag),
    .l2t_dirty              (l2t_dirty),
    .l2t_is_l2_fill         (l2t_is_l2_fill),
    .l2t_fill_way           (l2t_fill_way),
    .l2t_data_from_memory   (l2t_data_from_memory),
    .sweep_start            (sweep_start),
    .l2r_update_tag_en      (tag_en),
    .l2r_update_tag_set     (tag_set),
    .l2r_update_tag_valid   (tag_valid),
    .l2r_update_tag_value   (tag_value),
    .l2r_update_dirty_en    (dirty_en),
    .l2r_update_dirty_set   (dirty_set),
    .l2r_update_dirty_value (dirty_value),
    .l2r_update_lru_en      (lru_en),
    .l2r_update_lru_hit_way (lru_way),
    .sweep_busy             (sweep_busy),
    .sweep_done             (sweep_done),
`ifdef L2_TAG_PERF_COUNTERS_EN
    .perf_l2_hits           (perf_hits),
    .perf_l2_misses         (perf_misses),
`endif
    .l2u_request            (l2u_request),
    .l2u_hit                (l2u_hit),
    .l2u_hit_way            (l2u_hit_way),
    .l2u_is_l2_fill         (l2u_is_l2_fill),
    .l2u_data_from_memory   (l2u_data),
    .l2u_writeback_needed   (l2u_wb),
    .l2u_writeback_tag      (l2u_wb_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic l2_addr_t mk_addr(
    input logic [17:0] t,
    input logic [7:0]  s
  );
    return {t, s, 6'h00};
  endfunction

  task automatic set_req(
    input logic         v,
    input l2_pkt_type_t pt,
    input logic [17:0]  t,
    input logic [7:0]   s
  );
    l2t_request.valid       = v;
    l2t_request.packet_type = pt;
    l2t_request.address     = mk_addr(t, s);
  endtask

  task automatic default_ways();
    for (int w = 0; w < 8; w++) l2t_tag[w] = 18'h3000 + 18'(w);
    l2t_valid      = 8'hFF;
    l2t_dirty      = 8'h00;
    l2t_is_l2_fill = 1'b0;
    l2t_fill_way   = 3'd0;
  endtask

  task automatic idle_req();
    set_req(1'b0, PKT_LOAD, 18'h0, 8'h0);
    l2t_is_l2_fill = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    sweep_start = 1'b0;
    l2t_data_from_memory = '0;
    default_ways();
    l2t_tag[2] = 18'h123;
    set_req(1'b1, PKT_STORE, 18'h123, 8'd5);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tag_en", 64'(tag_en), 64'h0);
    chk("rst_dirty_en", 64'(dirty_en), 64'h0);
    chk("rst_lru_en", 64'(lru_en), 64'h0);
    chk("rst_busy", 64'(sweep_busy), 64'h0);
    chk("rst_done", 64'(sweep_done), 64'h0);
    chk("rst_l2u_hit", 64'(l2u_hit), 64'h0);
    chk("rst_l2u_req", 64'(l2u_request), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // load hit, way 2, set 5
    set_req(1'b1, PKT_LOAD, 18'h123, 8'd5);
    #1;
    chk("ld_lru_en", 64'(lru_en), 64'h1);
    chk("ld_lru_way", 64'(lru_way), 64'h2);
    chk("ld_tag_en", 64'(tag_en), 64'h0);
    chk("ld_dirty_en", 64'(dirty_en), 64'h0);
    @(posedge clk); #1;
    chk("ld_l2u_hit", 64'(l2u_hit), 64'h1);
    chk("ld_l2u_way", 64'(l2u_hit_way), 64'h2);
    chk("ld_l2u_wb", 64'(l2u_wb), 64'h0);

    // store hit, way 6, set 9
    @(negedge clk);
    default_ways();
    l2t_tag[6] = 18'h2ABC;
    set_req(1'b1, PKT_STORE, 18'h2ABC, 8'd9);
    #1;
    chk("st_dirty_en", 64'(dirty_en), 64'h40);
    chk("st_dirty_val", 64'(dirty_value), 64'h1);
    chk("st_dirty_set", 64'(dirty_set), 64'd9);
    chk("st_tag_en", 64'(tag_en), 64'h0);
    chk("st_lru_way", 64'(lru_way), 64'h6);

    // fill miss with dirty victim in way 4, set 3
    @(negedge clk);
    default_ways();
    l2t_tag[4]   = 18'h0AA;
    l2t_dirty[4] = 1'b1;
    l2t_is_l2_fill = 1'b1;
    l2t_fill_way   = 3'd4;
    l2t_data_from_memory = '0;
    l2t_data_from_memory[63:0] = 64'hDEAD_BEEF_0123_4567;
    set_req(1'b1, PKT_LOAD, 18'h1FF, 8'd3);
    #1;
    chk("fl_tag_en", 64'(tag_en), 64'h10);
    chk("fl_tag_val", 64'(tag_value), 64'h1FF);
    chk("fl_tag_valid", 64'(tag_valid), 64'h1);
    chk("fl_tag_set", 64'(tag_set), 64'd3);
    chk("fl_dirty_en", 64'(dirty_en), 64'h10);
    chk("fl_dirty_val", 64'(dirty_value), 64'h0);
    chk("fl_lru_way", 64'(lru_way), 64'h4);
    @(posedge clk); #1;
    chk("fl_wb", 64'(l2u_wb), 64'h1);
    chk("fl_wb_tag", 64'(l2u_wb_tag), 64'h0AA);
    chk("fl_l2u_hit", 64'(l2u_hit), 64'h0);
    chk("fl_l2u_way", 64'(l2u_hit_way), 64'h4);
    chk("fl_l2u_fill", 64'(l2u_is_l2_fill), 64'h1);
    chk("fl_l2u_data", l2u_data[63:0], 64'hDEAD_BEEF_0123_4567);

    // store fill, clean victim: dirty written 1, no writeback
    @(negedge clk);
    default_ways();
    l2t_is_l2_fill = 1'b1;
    l2t_fill_way   = 3'd7;
    set_req(1'b1, PKT_STORE, 18'h1FF, 8'd3);
    #1;
    chk("sf_dirty_en", 64'(dirty_en), 64'h80);
    chk("sf_dirty_val", 64'(dirty_value), 64'h1);
    @(posedge clk); #1;
    chk("sf_wb", 64'(l2u_wb), 64'h0);

    // fill that hits way 1: plain hit
    @(negedge clk);
    default_ways();
    l2t_is_l2_fill = 1'b1;
    l2t_fill_way   = 3'd5;
    set_req(1'b1, PKT_LOAD, 18'h3001, 8'd7);
    #1;
    chk("fh_tag_en", 64'(tag_en), 64'h0);
    chk("fh_lru_way", 64'(lru_way), 64'h1);
    @(posedge clk); #1;
    chk("fh_l2u_way", 64'(l2u_hit_way), 64'h1);
    chk("fh_wb", 64'(l2u_wb), 64'h0);

    // miss without fill: no updates
    @(negedge clk);
    default_ways();
    set_req(1'b1, PKT_LOAD, 18'h0777, 8'd2);
    #1;
    chk("ms_lru_en", 64'(lru_en), 64'h0);
    chk("ms_tag_en", 64'(tag_en), 64'h0);
    chk("ms_dirty_en", 64'(dirty_en), 64'h0);
    @(posedge clk); #1;
    chk("ms_l2u_hit", 64'(l2u_hit), 64'h0);

    // full sweep, no traffic; a second start mid-sweep is ignored
    @(negedge clk);
    idle_req();
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sweep_start = (i == 50);
      #1;
      chk("sw_busy", 64'(sweep_busy), 64'h1);
      chk("sw_tag_set", 64'(tag_set), 64'(i));
      chk("sw_dirty_set", 64'(dirty_set), 64'(i));
      chk("sw_en", {48'h0, tag_en, dirty_en}, 64'hFFFF);
      chk("sw_vals", 64'({tag_valid, dirty_value}), 64'h0);
      chk("sw_done_low", 64'(sweep_done), 64'h0);
      @(negedge clk);
    end
    sweep_start = 1'b0;
    #1;
    chk("sw_end_busy", 64'(sweep_busy), 64'h0);
    chk("sw_done", 64'(sweep_done), 64'h1);
    chk("sw_end_en", 64'(tag_en), 64'h0);
    @(negedge clk); #1;
    chk("sw_done_pulse", 64'(sweep_done), 64'h0);
    chk("sw_idle_busy", 64'(sweep_busy), 64'h0);

    // sweep with a load arriving at counter 17: 257 busy cycles
    @(negedge clk);
    default_ways();
    l2t_tag[2] = 18'h123;
    idle_req();
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    for (int k = 0; k < 257; k++) begin
      if (k == 17) set_req(1'b1, PKT_LOAD, 18'h123, 8'd5);
      else idle_req();
      #1;
      chk("ps_busy", 64'(sweep_busy), 64'h1);
      if (k == 17) begin
        chk("ps_ld_set", 64'(tag_set), 64'd5);
        chk("ps_ld_en", 64'(tag_en), 64'h0);
        chk("ps_ld_lru", 64'(lru_en), 64'h1);
      end else begin
        chk("ps_set", 64'(tag_set), 64'(k < 17 ? k : k - 1));
        chk("ps_en", 64'(tag_en), 64'hFF);
      end
      @(negedge clk);
    end
    idle_req();
    #1;
    chk("ps_end_busy", 64'(sweep_busy), 64'h0);
    chk("ps_done", 64'(sweep_done), 64'h1);

    // reset at counter 100, then restart from set 0
    @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    chk("rs_pre_set", 64'(tag_set), 64'd100);
    reset = 1'b0;
    #1;
    chk("rs_busy", 64'(sweep_busy), 64'h0);
    chk("rs_en", 64'(tag_en), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rs_idle", 64'(sweep_busy), 64'h0);
    @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    #1;
    chk("rs_restart_busy", 64'(sweep_busy), 64'h1);
    chk("rs_restart_set", 64'(tag_set), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
